// File: rtl/hex_cmd_sequencer_if.sv
// Handshake bundle between hex_cmd_sequencer, the UART rx/tx, the ascii_2_hex
// parser and the downstream value consumer.
interface hex_cmd_sequencer_if;
  logic        rx_tick;
  logic [7:0]  rx_byte;
  logic        a2h_drdy_tick;
  logic [63:0] a2h_ascii;
  logic        a2h_parsed_tick;
  logic [31:0] a2h_hex_result;
  logic [31:0] hex_value;
  logic        val_valid;
  logic        val_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;

  modport master (
    input  rx_tick, rx_byte, a2h_parsed_tick, a2h_hex_result, val_ready, tx_busy,
    output a2h_drdy_tick, a2h_ascii, hex_value, val_valid, tx_start, tx_byte
  );
  modport slave (
    output rx_tick, rx_byte, a2h_parsed_tick, a2h_hex_result, val_ready, tx_busy,
    input  a2h_drdy_tick, a2h_ascii, hex_value, val_valid, tx_start, tx_byte
  );
endinterface

// File: rtl/hex_cmd_sequencer.sv
// Collects hex digits from the UART into an 8-char buffer, hands it to ascii_2_hex,
// and presents the result on valid/ready. Optional echo: define HEXSEQ_ECHO_EN.
module hex_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  hex_cmd_sequencer_if.master bus,
  output logic                busy,
  output logic [3:0]          digit_count,
  output logic                err_char,
  output logic                err_overrun,
  output logic                err_timeout
);

  localparam int          TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [63:0] CLR = 64'h3030_3030_3030_3030;

  typedef enum logic [1:0] {COLLECT, DISPATCH, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0][7:0] buf_q, buf_nxt;
  logic [3:0]      cnt_q, cnt_nxt;
  logic [TW-1:0]   to_q, to_nxt;
  logic [31:0]     val_q, val_nxt;
  logic            e_char_nxt, e_ovr_nxt, e_to_nxt;
  logic            accept;
  logic            is_digit, is_term, is_esc;

  assign is_digit = bus.rx_byte inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]};
  assign is_term  = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
  assign is_esc   = (bus.rx_byte == 8'h1B);

  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    buf_nxt    = buf_q;
    cnt_nxt    = cnt_q;
    to_nxt     = to_q;
    val_nxt    = val_q;
    e_char_nxt = 1'b0;
    e_ovr_nxt  = 1'b0;
    e_to_nxt   = 1'b0;
    accept     = 1'b0;
    case (state)
      COLLECT: if (bus.rx_tick) begin
        if (is_digit) begin
          accept  = 1'b1;
          buf_nxt = {buf_q[6:0], bus.rx_byte};
          cnt_nxt = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_nxt = DISPATCH;
        end else if (is_term) begin
          accept = 1'b1;
          if (cnt_q != 4'd0) state_nxt = DISPATCH;
        end else if (is_esc) begin
          accept  = 1'b1;
          buf_nxt = CLR;
          cnt_nxt = 4'd0;
        end else begin
          e_char_nxt = 1'b1;
        end
      end
      DISPATCH: begin
        state_nxt = WAIT;
        to_nxt    = TW'(TIMEOUT_CYCLES);
      end
      WAIT: begin
        // a result arriving in the last counted cycle still wins over the timeout
        if (bus.a2h_parsed_tick) begin
          val_nxt   = bus.a2h_hex_result;
          state_nxt = HOLD;
        end else if (to_q <= TW'(1)) begin
          e_to_nxt  = 1'b1;
          buf_nxt   = CLR;
          cnt_nxt   = 4'd0;
          state_nxt = COLLECT;
        end else begin
          to_nxt = to_q - TW'(1);
        end
      end
      HOLD: if (bus.val_ready) begin
        buf_nxt   = CLR;
        cnt_nxt   = 4'd0;
        state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
    if (bus.rx_tick && state != COLLECT) e_ovr_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_q       <= CLR;
      cnt_q       <= 4'd0;
      to_q        <= '0;
      val_q       <= 32'd0;
      err_char    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      buf_q       <= buf_nxt;
      cnt_q       <= cnt_nxt;
      to_q        <= to_nxt;
      val_q       <= val_nxt;
      err_char    <= e_char_nxt;
      err_overrun <= e_ovr_nxt;
      err_timeout <= e_to_nxt;
    end
  end

  assign bus.a2h_drdy_tick = (state == DISPATCH);
  assign bus.a2h_ascii     = buf_q;
  assign bus.hex_value     = val_q;
  assign bus.val_valid     = (state == HOLD);
  assign busy              = (state != COLLECT);
  assign digit_count       = cnt_q;

`ifdef HEXSEQ_ECHO_EN
  logic       tx_start_q;
  logic [7:0] tx_byte_q;

  // echo is best-effort: a busy transmitter simply loses the character
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'd0;
    end else begin
      tx_start_q <= accept & ~bus.tx_busy;
      if (accept && !bus.tx_busy) tx_byte_q <= bus.rx_byte;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_byte  = tx_byte_q;
`else
  logic unused_echo;
  assign unused_echo  = accept ^ bus.tx_busy;
  assign bus.tx_start = 1'b0;
  assign bus.tx_byte  = 8'd0;
`endif

endmodule

// File: tb/tb_hex_cmd_sequencer.sv
// Directed + randomized bench for hex_cmd_sequencer; the bench plays UART, parser
// and consumer, and predicts behaviour from a queue of buffered digits.
module tb_hex_cmd_sequencer;
  localparam int          T   = 4;
  localparam logic [63:0] CLR = 64'h3030_3030_3030_3030;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [3:0] digit_count;
  logic       err_char, err_overrun, err_timeout;

  hex_cmd_sequencer_if bus();

  hex_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .digit_count(digit_count),
    .err_char(err_char), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int         ntests = 0;
  int         nfail  = 0;
  logic [7:0] q[$];
  logic [31:0] last_val = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [63:0] model_ascii();
    logic [63:0] a;
    for (int i = 0; i < 8; i++)
      a[8*i +: 8] = (i < q.size()) ? q[q.size()-1-i] : 8'h30;
    return a;
  endfunction

  function automatic logic [3:0] nib(input logic [7:0] c);
    if (c <= 8'h39)      return 4'(c - 8'h30);
    else if (c <= 8'h46) return 4'(c - 8'h41 + 8'd10);
    else                 return 4'(c - 8'h61 + 8'd10);
  endfunction

  function automatic logic [31:0] ascii2val(input logic [63:0] a);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = nib(a[8*i +: 8]);
    return v;
  endfunction

  task automatic check_reset_vals(input string p);
    chk({p, "_drdy"}, bus.a2h_drdy_tick, 0);
    chk({p, "_ascii"}, bus.a2h_ascii, CLR);
    chk({p, "_hex"}, bus.hex_value, 0);
    chk({p, "_valid"}, bus.val_valid, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_count"}, digit_count, 0);
    chk({p, "_errs"}, {err_char, err_overrun, err_timeout}, 0);
    chk({p, "_tx"}, {bus.tx_start, bus.tx_byte}, 0);
  endtask

  // one byte offered while the sequencer is collecting
  task automatic send(input logic [7:0] b, input bit txb, output bit dispatched);
    bit acc, ex_drdy;
    acc = 1'b0; ex_drdy = 1'b0;
    bus.rx_tick = 1'b1; bus.rx_byte = b; bus.tx_busy = txb;
    @(negedge clk);
    bus.rx_tick = 1'b0; bus.tx_busy = 1'b0;
    if (is_hex(b)) begin
      q.push_back(b); acc = 1'b1; ex_drdy = (q.size() == 8);
    end else if (b == 8'h0D || b == 8'h0A) begin
      acc = 1'b1; ex_drdy = (q.size() > 0);
    end else if (b == 8'h1B) begin
      acc = 1'b1; q.delete();
    end
    chk("err_char", err_char, !acc);
    chk("err_overrun_collect", err_overrun, 0);
    chk("drdy", bus.a2h_drdy_tick, ex_drdy);
    chk("digit_count", digit_count, q.size());
    if (ex_drdy) chk("a2h_ascii", bus.a2h_ascii, model_ascii());
`ifdef HEXSEQ_ECHO_EN
    chk("tx_start", bus.tx_start, acc && !txb);
    if (acc && !txb) chk("tx_byte", bus.tx_byte, b);
`else
    chk("tx_start", bus.tx_start, 0);
    chk("tx_byte", bus.tx_byte, 0);
`endif
    dispatched = ex_drdy;
  endtask

  // entered at the negedge where a2h_drdy_tick is seen; acts as parser and consumer
  task automatic parse_phase(input bit tmo, input int k, input bit ovr_disp,
                             input int hold, input int n_ovr);
    logic [63:0] a;
    logic [31:0] res;
    a = model_ascii();
    res = ascii2val(a);
    if (ovr_disp) begin bus.rx_tick = 1'b1; bus.rx_byte = 8'($urandom); end
    if (tmo) begin
      for (int j = 1; j <= T + 1; j++) begin
        @(negedge clk);
        bus.rx_tick = 1'b0;
        if (j == 1) chk("overrun_dispatch", err_overrun, ovr_disp);
        chk("err_timeout", err_timeout, j == T + 1);
        chk("busy_wait", busy, j <= T);
        if (j <= T) chk("ascii_stable", bus.a2h_ascii, a);
      end
      q.delete();
      chk("ascii_after_timeout", bus.a2h_ascii, CLR);
      chk("count_after_timeout", digit_count, 0);
      chk("hex_after_timeout", bus.hex_value, last_val);
    end else begin
      for (int j = 1; j <= k; j++) begin
        @(negedge clk);
        bus.rx_tick = 1'b0;
        if (j == 1) chk("overrun_dispatch", err_overrun, ovr_disp);
        chk("no_timeout", err_timeout, 0);
        chk("valid_low_wait", bus.val_valid, 0);
        chk("ascii_stable", bus.a2h_ascii, a);
      end
      bus.a2h_hex_result = res; bus.a2h_parsed_tick = 1'b1;
      @(negedge clk);
      bus.a2h_parsed_tick = 1'b0; bus.a2h_hex_result = 32'($urandom);
      chk("valid_on_result", bus.val_valid, 1);
      chk("hex_on_result", bus.hex_value, res);
      chk("no_timeout_result", err_timeout, 0);
      for (int h = 0; h < hold; h++) begin
        if (h < n_ovr) begin bus.rx_tick = 1'b1; bus.rx_byte = 8'($urandom); end
        if (h == hold - 1) begin bus.a2h_parsed_tick = 1'b1; bus.a2h_hex_result = ~res; end
        @(negedge clk);
        bus.rx_tick = 1'b0; bus.a2h_parsed_tick = 1'b0;
        chk("overrun_hold", err_overrun, h < n_ovr);
        chk("hold_hex", bus.hex_value, res);
        chk("hold_valid", bus.val_valid, 1);
      end
      bus.val_ready = 1'b1;
      @(negedge clk);
      bus.val_ready = 1'b0;
      chk("valid_after_ready", bus.val_valid, 0);
      chk("busy_after_ready", busy, 0);
      chk("hex_retained", bus.hex_value, res);
      chk("ascii_after_ready", bus.a2h_ascii, CLR);
      q.delete();
      last_val = res;
    end
  endtask

  task automatic send_str(input string s, input bit txb, output bit d);
    for (int i = 0; i < s.len(); i++) send(s[i], txb, d);
  endtask

  bit          d;
  int          r, guard;
  logic [7:0]  b;
  string       digs = "0123456789abcdefABCDEF";

  initial begin
    bus.rx_tick = 1'b0; bus.rx_byte = 8'd0; bus.a2h_parsed_tick = 1'b0;
    bus.a2h_hex_result = 32'd0; bus.val_ready = 1'b0; bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // eight digits, no terminator
    send_str("01020304", 1'b0, d);
    chk("dispatch_8th", d, 1);
    chk("ascii_01020304", bus.a2h_ascii, 64'h3031_3032_3033_3034);
    parse_phase(1'b0, 2, 1'b0, 3, 0);
    chk("hex_01020304", bus.hex_value, 32'h0102_0304);

    // short command with CR, result in the final timeout cycle
    send_str("aB", 1'b0, d);
    send(8'h0D, 1'b0, d);
    chk("ascii_aB", bus.a2h_ascii, 64'h3030_3030_3030_6142);
    chk("count_aB", digit_count, 2);
    parse_phase(1'b0, T, 1'b0, 1, 0);
    send(8'h0D, 1'b0, d);
    chk("cr_empty_no_dispatch", d, 0);

    // illegal char and ESC
    send_str("12G3", 1'b0, d);
    send(8'h1B, 1'b0, d);
    send_str("7", 1'b0, d);
    send(8'h0A, 1'b0, d);
    chk("ascii_7", bus.a2h_ascii, 64'h3030_3030_3030_3037);
    parse_phase(1'b0, 1, 1'b1, 2, 0);

    // parser timeout with an overrun during dispatch
    send_str("9", 1'b0, d);
    send(8'h0D, 1'b0, d);
    parse_phase(1'b1, 0, 1'b1, 0, 0);

    // long hold with two overrun bytes
    send_str("F", 1'b0, d);
    send(8'h0A, 1'b0, d);
    parse_phase(1'b0, 1, 1'b0, 10, 2);

    // echo sequence, then reset while waiting on the parser
    send_str("5", 1'b0, d);
    send(8'h0D, 1'b0, d);
    parse_phase(1'b0, 1, 1'b0, 1, 0);
    send_str("6", 1'b1, d);
    send(8'h0D, 1'b0, d);
    @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b1;
    q.delete();
    last_val = 32'd0;

    // stray parser pulse while collecting
    bus.a2h_parsed_tick = 1'b1; bus.a2h_hex_result = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.a2h_parsed_tick = 1'b0;
    chk("stray_parsed_valid", bus.val_valid, 0);
    chk("stray_parsed_hex", bus.hex_value, 0);

    // randomized command streams
    for (int t = 0; t < 40; t++) begin
      d = 1'b0; guard = 0;
      while (!d && guard < 40) begin
        r = $urandom_range(0, 19);
        if (r < 12)       b = digs[$urandom_range(0, 21)];
        else if (r < 14)  b = (r == 12) ? 8'h0D : 8'h0A;
        else if (r == 14) b = 8'h1B;
        else begin
          b = 8'($urandom);
          while (is_hex(b) || b == 8'h0D || b == 8'h0A || b == 8'h1B) b = 8'($urandom);
        end
        send(b, 1'($urandom_range(0, 1)), d);
        guard++;
      end
      if (d) parse_phase($urandom_range(0, 4) == 0, $urandom_range(1, T),
                         1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/hex_cmd_sequencer.md
# hex_cmd_sequencer

Sequencer that sits between the UART receiver and the `ascii_2_hex` parser. Collects received hex-digit characters into an 8-character ASCII buffer and fires the parser's `drdy_tick`. Waits for `parsed_tick` with a timeout, then presents the 32-bit result to the downstream consumer via a valid/ready handshake. Malformed input, overrun and parser timeout are reported as single-cycle error pulses.

## Interface
- `TIMEOUT_CYCLES`, 64: cycles allowed in WAIT for `parsed_tick` before abort.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rx_tick` in 1: one-cycle pulse, `rx_byte` valid.
- `rx_byte` in 8: received ASCII character.
- `a2h_drdy_tick` out 1: one-cycle pulse to parser, `a2h_ascii` valid.
- `a2h_ascii` out 64: 8 ASCII chars, most significant digit in [63:56].
- `a2h_parsed_tick` in 1: parser done pulse.
- `a2h_hex_result` in 32: parser result, sampled on `a2h_parsed_tick`.
- `hex_value` out 32: registered result.
- `val_valid` out 1: `hex_value` available.
- `val_ready` in 1: consumer accepts `hex_value`.
- `busy` out 1: high in DISPATCH, WAIT and HOLD.
- `digit_count` out 4: digits currently buffered, 0–8.
- `err_char` out 1: pulse, illegal character received.
- `err_overrun` out 1: pulse, byte arrived while not in COLLECT.
- `err_timeout` out 1: pulse, parser timed out.
- `tx_start` out 1: echo strobe (see Configuration).
- `tx_byte` out 8: echo data.
- `tx_busy` in 1: UART transmitter busy.

## Operation
- States: COLLECT (reset state) → DISPATCH → WAIT → HOLD → COLLECT.
- Buffer cleared value: 64'h3030_3030_3030_3030 (eight ASCII '0'), `digit_count` = 0. Shifting into a '0'-filled buffer gives implicit left zero-padding.
- COLLECT, `rx_tick` with:
  - Hex digit 0x30–0x39, 0x41–0x46 or 0x61–0x66: buffer <= {buffer[55:0], rx_byte}; count++. The 8th digit moves the FSM to DISPATCH.
  - CR 0x0D or LF 0x0A: if count ≥ 1, go to DISPATCH; if count = 0, ignore (no error).
  - ESC 0x1B: clear buffer and count; no error.
  - Any other byte: pulse `err_char`; buffer and count unchanged.
- DISPATCH: `a2h_drdy_tick` = 1 for exactly one cycle; next state WAIT; timeout counter loaded with `TIMEOUT_CYCLES`.
- WAIT:
  - On `a2h_parsed_tick`: `hex_value` <= `a2h_hex_result`; go to HOLD.
  - Otherwise the counter decrements. When it reaches 0: pulse `err_timeout`, clear buffer, return to COLLECT.
- HOLD: `val_valid` = 1 and `hex_value` held stable. When `val_ready` = 1: clear buffer, return to COLLECT. `hex_value` retains its last value after the handshake.
- `rx_tick` in any state other than COLLECT: byte dropped, pulse `err_overrun`.
- `a2h_parsed_tick` outside WAIT: ignored.
- `a2h_ascii` is driven directly from the buffer and stays stable from DISPATCH until the FSM leaves WAIT.

## Timing
- Outputs after reset: `a2h_drdy_tick` 0; `a2h_ascii` 64'h3030_3030_3030_3030; `hex_value` 0; `val_valid` 0; `busy` 0; `digit_count` 0; all `err_*` 0; `tx_start` 0; `tx_byte` 0.
- Reset taken mid-operation (any state) returns to COLLECT on the next edge; no pulses are emitted in that cycle.
- Dispatch latency: `rx_tick` carrying the 8th digit or the terminator at cycle N gives `a2h_drdy_tick` = 1 at N+1 and state WAIT at N+2.
- Result latency: `a2h_parsed_tick` at cycle M gives `val_valid` = 1 and `hex_value` loaded at M+1.
- Handshake: `val_ready` sampled at cycle K while `val_valid` = 1 gives `val_valid` = 0 and `busy` = 0 at K+1. A byte arriving at K+1 is accepted.
- Timeout: with no `a2h_parsed_tick`, `err_timeout` pulses `TIMEOUT_CYCLES` + 1 cycles after `a2h_drdy_tick`.
- Simultaneous events:
  - `a2h_parsed_tick` in the final timeout cycle: the result wins; no error.
  - `rx_tick` during DISPATCH or WAIT: overrun reported; the parse is unaffected.
- All `err_*` pulses are registered, one cycle after the causing `rx_tick` or expiry.

## Configuration
- `HEXSEQ_ECHO_EN` defined:
  - Every byte accepted in COLLECT (digit, terminator, ESC) is echoed: `tx_byte` <= `rx_byte` and `tx_start` pulses one cycle after `rx_tick`.
  - If `tx_busy` = 1 in that cycle, the echo is silently dropped.
  - Illegal and overrun bytes are never echoed.
- `HEXSEQ_ECHO_EN` undefined: `tx_start` and `tx_byte` tied to 0; `tx_busy` ignored.

## Test plan
- Send "01020304" with no terminator → `a2h_drdy_tick` one cycle after the 8th `rx_tick`; `a2h_ascii` = "01020304"; after `a2h_parsed_tick` with result 32'h01020304, `hex_value` = 32'h01020304 and `val_valid` = 1.
- Send "aB", CR → `a2h_ascii` = "000000aB" and `digit_count` = 2 at dispatch. Then CR with an empty buffer → no `a2h_drdy_tick`.
- Send "12", 'G', "3", ESC, "7", LF → `err_char` pulses once; ESC clears the buffer; the dispatch carries "00000007".
- Dispatch, then withhold `a2h_parsed_tick` with `TIMEOUT_CYCLES` = 4 → `err_timeout` 5 cycles after `a2h_drdy_tick`; back in COLLECT with buffer "00000000".
- In HOLD, hold `val_ready` = 0 for 10 cycles and send 2 bytes → `err_overrun` pulses twice; `hex_value` stays stable; `val_ready` = 1 → `val_valid` drops the next cycle.
- With `HEXSEQ_ECHO_EN` defined, send "5" then CR with `tx_busy` = 0, then "6" with `tx_busy` = 1 → `tx_start` pulses for 0x35 and 0x0D only. Assert `reset` = 0 during WAIT → all outputs return to their reset values the next cycle.
